// File: rtl/proj_gfm_collector.sv
// Reassembles one-hot fragment parts into a packed fragment record
// and restores the unsigned k-mer index from the centred window index.
module proj_gfm_collector #(
    parameter int FRAG_SIZE         = 256,
    parameter int KMER_SIZE         = 16,
    parameter int BASE_LEN          = 2,
    parameter int ONE_HOT_LEN       = 4,
    parameter int FRAG_PART         = 32,
    parameter int FRAG_PART_ONE_HOT = 64,
    parameter int INDICE_LEN        = 8,
    parameter int SIGNED_INDICE_LEN = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         in_first,
    input  logic [FRAG_PART_ONE_HOT-1:0] in_gfm,
    input  logic [SIGNED_INDICE_LEN-1:0] in_index,
    output logic                         out_valid,
    output logic [FRAG_SIZE*BASE_LEN-1:0] out_fragment,
    output logic [INDICE_LEN-1:0]        out_index,
    output logic                         out_err,
    output logic                         out_abort
);

    localparam int FRAG_LEN_BITS = FRAG_SIZE * BASE_LEN;
    localparam int PARTS         = FRAG_LEN_BITS / FRAG_PART;
    localparam int OFFSET        = (FRAG_SIZE - KMER_SIZE) >> 1;
    localparam int NIBS          = FRAG_PART / BASE_LEN;
    localparam int CW            = (PARTS > 1) ? $clog2(PARTS) : 1;
    localparam int SW            = SIGNED_INDICE_LEN + 1;

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t                       state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [FRAG_LEN_BITS-1:0]     asm_q, asm_d;
    logic                         acc_q, acc_d;
    logic [SIGNED_INDICE_LEN-1:0] idx_q, idx_d;
    logic                         valid_q, valid_d;
    logic                         abort_q, abort_d;
    logic [FRAG_LEN_BITS-1:0]     frag_q, frag_d;
    logic [INDICE_LEN-1:0]        oidx_q, oidx_d;
    logic                         oerr_q, oerr_d;

    logic [FRAG_PART-1:0]         dec_part;
    logic                         beat_err;
    logic                         complete;
    logic [SW-1:0]                sum_ext;

    always_comb begin
        dec_part = '0;
        beat_err = 1'b0;
        for (int i = 0; i < NIBS; i++) begin
            unique case (in_gfm[i*ONE_HOT_LEN +: ONE_HOT_LEN])
                4'b0001: dec_part[i*BASE_LEN +: BASE_LEN] = BASE_LEN'(0);
                4'b0010: dec_part[i*BASE_LEN +: BASE_LEN] = BASE_LEN'(1);
                4'b0100: dec_part[i*BASE_LEN +: BASE_LEN] = BASE_LEN'(2);
                4'b1000: dec_part[i*BASE_LEN +: BASE_LEN] = BASE_LEN'(3);
                default: beat_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        valid_d  = 1'b0;
        abort_d  = 1'b0;
        frag_d   = frag_q;
        oidx_d   = oidx_q;
        oerr_d   = oerr_q;
        complete = 1'b0;
        if (in_valid) begin
            if (in_first) begin
                // a new part 0 always restarts, dropping any partial window
                abort_d = (state_q == COLLECT);
                asm_d[FRAG_PART-1:0] = dec_part;
                idx_d   = in_index;
                acc_d   = beat_err;
                cnt_d   = CW'(1);
                state_d = COLLECT;
                if (PARTS == 1) complete = 1'b1;
            end else if (state_q == COLLECT) begin
                asm_d[int'(cnt_q)*FRAG_PART +: FRAG_PART] = dec_part;
                acc_d = acc_q | beat_err | (in_index != idx_q);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(PARTS - 1)) complete = 1'b1;
            end
        end
        // one extra bit exposes both negative and overflowing sums
        sum_ext = {idx_d[SIGNED_INDICE_LEN-1], idx_d} + SW'(OFFSET);
        if (complete) begin
            valid_d = 1'b1;
            frag_d  = asm_d;
            oidx_d  = sum_ext[INDICE_LEN-1:0];
            oerr_d  = acc_d | (|sum_ext[SW-1:INDICE_LEN]);
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            asm_q   <= '0;
            acc_q   <= 1'b0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            abort_q <= 1'b0;
            frag_q  <= '0;
            oidx_q  <= '0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            abort_q <= abort_d;
            frag_q  <= frag_d;
            oidx_q  <= oidx_d;
            oerr_q  <= oerr_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_abort    = abort_q;
    assign out_fragment = frag_q;
    assign out_index    = oidx_q;
    assign out_err      = oerr_q;

endmodule

// File: doc/proj_gfm_collector.md
Name: proj_gfm_collector

Overview:
- Receive-side counterpart of the fragment extender.
- Accepts the extender's stream of one-hot fragment parts together with its signed, centred window index.
- Decodes each one-hot base back to its 2-bit code and reassembles the full packed fragment.
- Restores the unsigned k-mer index and presents one fragment/index record per window to downstream scoring, with an integrity flag.

Parameters:
- FRAG_SIZE, 256: fragment length in bases.
- KMER_SIZE, 16: k-mer length in bases; sets the centring offset.
- BASE_LEN, 2: bits per packed base.
- ONE_HOT_LEN, 4: bits per one-hot base.
- FRAG_PART, 32: packed bits per part (16 bases).
- FRAG_PART_ONE_HOT, 64: one-hot bits per part, equal to FRAG_PART*ONE_HOT_LEN/BASE_LEN.
- INDICE_LEN, 8: unsigned k-mer index width.
- SIGNED_INDICE_LEN, 9: signed window index width, equal to INDICE_LEN+1.
- Derived: FRAG_LEN_BITS = FRAG_SIZE*BASE_LEN (512).
- Derived: PARTS = FRAG_LEN_BITS/FRAG_PART (16).
- Derived: OFFSET = (FRAG_SIZE-KMER_SIZE)>>1 (120).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat qualifier; in_gfm and in_index are sampled only when high.
- in_first  in  1  marks part 0 of a window; ignored unless in_valid.
- in_gfm  in  FRAG_PART_ONE_HOT  one-hot bases of the current part; nibble i is base i.
- in_index  in  SIGNED_INDICE_LEN  signed centred index, constant across a window.
- out_valid  out  1  one-cycle pulse: record complete.
- out_fragment  out  FRAG_LEN_BITS  reassembled packed fragment; part k is at bits [k*FRAG_PART +: FRAG_PART].
- out_index  out  INDICE_LEN  restored unsigned index.
- out_err  out  1  qualified by out_valid; window had a bad nibble or an index mismatch.
- out_abort  out  1  one-cycle pulse: an incomplete window was discarded.

Behaviour:
- Single clock domain. All outputs are registered.
- Reset values: out_valid=0, out_abort=0, out_err=0, out_fragment=0, out_index=0. Internal state: state=IDLE, part counter=0, error accumulator=0.
- Reset has priority over every other event. A reset mid-window discards the window and does not pulse out_abort.

States:
- IDLE: waits for in_valid&in_first.
  - A beat with in_first=0 is dropped silently; no abort is raised.
  - On the first beat:
    - write part 0;
    - capture in_index;
    - load the error accumulator with part 0's nibble errors;
    - set counter=1;
    - go to COLLECT.
- COLLECT: each in_valid beat with in_first=0:
  - writes part[counter];
  - ORs that beat's nibble errors into the accumulator;
  - ORs in (in_index != captured index);
  - increments the counter.
- in_valid low: hold everything. Gaps of any length are legal.
- Last part: the beat with counter==PARTS-1 completes the window.
  - Next cycle: out_valid=1; out_fragment, out_index and out_err are updated.
  - State returns to IDLE, counter=0.
  - Latency: last beat accepted at cycle N gives out_valid at N+1.
- Record hold: out_fragment, out_index and out_err hold until the next record. out_valid lasts exactly one cycle.
- Back-to-back windows: an in_first beat in the cycle after the last part (or in the same cycle as out_valid) is accepted as part 0 of the next window with no bubble. This requires a shadow assembly register separate from out_fragment.
- in_first while COLLECT (counter>0):
  - the partial window is discarded and out_abort pulses the next cycle;
  - that beat becomes part 0 of a new window (counter=1);
  - out_valid is not asserted for the discarded window.
- Single-part edge case (PARTS==1): an in_first beat completes the window immediately.

Decode, per nibble:
- 0001 -> 00
- 0010 -> 01
- 0100 -> 10
- 1000 -> 11
- Any other value (zero or multi-hot) -> 00 and sets the error.

Index restore:
- out_index = (in_index + OFFSET) computed at SIGNED_INDICE_LEN width, truncated to INDICE_LEN. No saturation.
- If the sum is negative or >= 2^INDICE_LEN, out_err is forced to 1 for that record.

Counter:
- Width is clog2(PARTS).
- The counter never wraps inside a window; completion resets it explicitly.

Test Plan:
1. Reset, then 16 beats: in_first on beat 0, in_index=-120, part k has every nibble encoding code k mod 4 -> one cycle after beat 15: out_valid=1, out_index=0, out_err=0, and every 2-bit base of part k equals k mod 4.
2. Same window with in_valid deasserted for 3 cycles between parts 5 and 6 -> identical record; out_valid arrives 3 cycles later than in scenario 1.
3. Part 9, nibble 3 set to 4'b0110 -> record with out_err=1 and that base decoded as 00. In_index 10 on beat 0 and 11 on beat 4 -> out_err=1, out_index=130.
4. in_first reasserted at beat 7 with in_index=5, followed by 15 more parts -> out_abort pulse one cycle after that beat; one record with out_index=125; exactly one out_valid.
5. Two windows back-to-back with zero gap (indices -120, then 135) -> out_valid on two cycles 16 apart; out_index 0 then 255; second record has out_err=0. Also check in_index=136 -> out_err=1.
6. rst asserted at beat 10 -> all outputs 0 next cycle, no out_abort; a following full window completes normally.
